// File: rtl/pea_switch_pkg.sv
// Shared types and constants for the buffer/PE-array mode switch.
package pea_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    QUIET  = 2'd3
  } state_t;

  localparam int unsigned MODE_IDLE  = 0;
  localparam int unsigned MODE_CONV  = 1;
  localparam int unsigned MODE_DENSE = 2;
  localparam int unsigned MODE_POOL  = 3;

  // Per-buffer control word layout {r_en, r_addr, w_en, w_addr}
  localparam int unsigned BCTRL_ADDR_W     = 11;
  localparam int unsigned BCTRL_W_ADDR_LSB = 0;
  localparam int unsigned BCTRL_W_EN_BIT   = 11;
  localparam int unsigned BCTRL_R_ADDR_LSB = 12;
  localparam int unsigned BCTRL_R_EN_BIT   = 23;

endpackage

// File: rtl/pea_bus_router.sv
// Combinational crossbar: PE-array input bus j takes buffer route[j]; out-of-range routes take buffer 0.
module pea_bus_router #(
  parameter int unsigned N_BUF  = 2,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BSEL_W = 1
) (
  input  logic [N_BUF*BSEL_W-1:0] route,
  input  logic [N_BUF*DATA_W-1:0] buf_rdata,
  output logic [N_BUF*DATA_W-1:0] pea_in_bus
);

  always_comb begin
    pea_in_bus = '0;
    for (int j = 0; j < N_BUF; j++) begin
      pea_in_bus[j*DATA_W +: DATA_W] = buf_rdata[0 +: DATA_W];
      for (int i = 1; i < N_BUF; i++) begin
        if (route[j*BSEL_W +: BSEL_W] == BSEL_W'(i)) begin
          pea_in_bus[j*DATA_W +: DATA_W] = buf_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/buffer_pea_switch.sv
// Mode register and control/data routing between compute controllers, buffers and the PE array.
// Optional feature: define SWITCH_COUNT_EN to build the saturating switch counter.
module buffer_pea_switch
  import pea_switch_pkg::*;
#(
  parameter int unsigned N_MODES = 3,
  parameter int unsigned N_BUF   = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned BCTRL_W = 24,
  parameter int unsigned PCTRL_W = 64,
  parameter int unsigned GUARD   = 2,
  parameter int unsigned MODE_W  = $clog2(N_MODES + 1),
  parameter int unsigned BSEL_W  = $clog2(N_BUF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MODE_W-1:0]                 mode_req,
  input  logic                              mode_req_valid,
  output logic                              mode_req_ready,
  input  logic [N_MODES-1:0]                ctrl_busy,
  input  logic [N_MODES*N_BUF*BCTRL_W-1:0]  buf_ctrl_in,
  input  logic [N_MODES*PCTRL_W-1:0]        pea_ctrl_in,
  input  logic [N_MODES*N_BUF*BSEL_W-1:0]   route_in,
  input  logic [N_BUF*DATA_W-1:0]           buf_rdata,
  input  logic [DATA_W-1:0]                 pea_out_bus,
  output logic [N_BUF*BCTRL_W-1:0]          buf_ctrl_out,
  output logic [PCTRL_W-1:0]                pea_ctrl_out,
  output logic [N_BUF*DATA_W-1:0]           pea_in_bus,
  output logic [N_BUF*DATA_W-1:0]           buf_wdata,
  output logic [MODE_W-1:0]                 mode_active,
  output logic                              switching,
  output logic                              bad_mode,
  output logic [15:0]                       switch_count
);

  localparam int unsigned GCNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned BSLICE = N_BUF * BCTRL_W;
  localparam int unsigned RSLICE = N_BUF * BSEL_W;

  state_t              state, state_nxt;
  logic [MODE_W-1:0]   pending, pend_nxt, mode_nxt;
  logic [GCNT_W-1:0]   gcnt, gcnt_nxt;
  logic                ready_nxt, switching_nxt;

  logic                req_fire_c, req_bad_c, busy_cur_c;
  logic [MODE_W-1:0]   req_mode_c;
  logic [BSLICE-1:0]   sel_buf_c;
  logic [PCTRL_W-1:0]  sel_pea_c;
  logic [RSLICE-1:0]   route_c;

  assign req_fire_c = mode_req_valid & mode_req_ready;
  assign req_bad_c  = (mode_req > MODE_W'(N_MODES));
  assign req_mode_c = req_bad_c ? MODE_W'(MODE_IDLE) : mode_req;

  // Select the granted mode's controls, busy flag and route; mode 0 gives zeros and identity route
  always_comb begin
    busy_cur_c = 1'b0;
    sel_buf_c  = '0;
    sel_pea_c  = '0;
    route_c    = '0;
    for (int j = 0; j < N_BUF; j++) begin
      route_c[j*BSEL_W +: BSEL_W] = BSEL_W'(j);
    end
    for (int k = 0; k < N_MODES; k++) begin
      if (mode_active == MODE_W'(k + 1)) begin
        busy_cur_c = ctrl_busy[k];
        sel_buf_c  = buf_ctrl_in[k*BSLICE +: BSLICE];
        sel_pea_c  = pea_ctrl_in[k*PCTRL_W +: PCTRL_W];
        route_c    = route_in[k*RSLICE +: RSLICE];
      end
    end
  end

  // Next-state logic for the drain / quiet-guard switching sequence
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_active;
    pend_nxt  = pending;
    gcnt_nxt  = gcnt;
    case (state)
      IDLE: begin
        if (req_fire_c && req_mode_c != MODE_W'(MODE_IDLE)) begin
          state_nxt = QUIET;
          pend_nxt  = req_mode_c;
          gcnt_nxt  = GCNT_W'(GUARD - 1);
        end
      end
      ACTIVE: begin
        if (req_fire_c && req_mode_c != mode_active) begin
          state_nxt = DRAIN;
          pend_nxt  = req_mode_c;
        end
      end
      DRAIN: begin
        if (!busy_cur_c) begin
          state_nxt = QUIET;
          mode_nxt  = MODE_W'(MODE_IDLE);
          gcnt_nxt  = GCNT_W'(GUARD - 1);
        end
      end
      QUIET: begin
        if (gcnt == '0) begin
          state_nxt = (pending != MODE_W'(MODE_IDLE)) ? ACTIVE : IDLE;
          mode_nxt  = pending;
        end else begin
          gcnt_nxt = gcnt - GCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt     = (state_nxt == IDLE) || (state_nxt == ACTIVE);
    switching_nxt = (state_nxt == DRAIN) || (state_nxt == QUIET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode_active    <= '0;
      pending        <= '0;
      gcnt           <= '0;
      mode_req_ready <= 1'b1;
      switching      <= 1'b0;
      bad_mode       <= 1'b0;
      buf_ctrl_out   <= '0;
      pea_ctrl_out   <= '0;
    end else begin
      state          <= state_nxt;
      mode_active    <= mode_nxt;
      pending        <= pend_nxt;
      gcnt           <= gcnt_nxt;
      mode_req_ready <= ready_nxt;
      switching      <= switching_nxt;
      buf_ctrl_out   <= sel_buf_c;
      pea_ctrl_out   <= sel_pea_c;
      if (req_fire_c && req_bad_c) bad_mode <= 1'b1;
    end
  end

`ifdef SWITCH_COUNT_EN
  logic [15:0] switch_cnt_q;

  // Counts every exit from the quiet window, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      switch_cnt_q <= '0;
    end else if (state == QUIET && gcnt == '0 && switch_cnt_q != 16'hFFFF) begin
      switch_cnt_q <= switch_cnt_q + 16'd1;
    end
  end

  assign switch_count = switch_cnt_q;
`else
  assign switch_count = '0;
`endif

  assign buf_wdata = {N_BUF{pea_out_bus}};

  pea_bus_router #(
    .N_BUF  (N_BUF),
    .DATA_W (DATA_W),
    .BSEL_W (BSEL_W)
  ) u_router (
    .route      (route_c),
    .buf_rdata  (buf_rdata),
    .pea_in_bus (pea_in_bus)
  );

endmodule

// File: tb/tb_buffer_pea_switch.sv
// Self-checking bench for buffer_pea_switch: directed and random mode switches against a cycle-schedule model.
module tb_buffer_pea_switch;

  localparam int unsigned N_MODES = 3;
  localparam int unsigned N_BUF   = 2;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned BCTRL_W = 24;
  localparam int unsigned PCTRL_W = 64;
  localparam int unsigned GUARD   = 2;
  localparam int unsigned MODE_W  = 3;
  localparam int unsigned BSEL_W  = 1;
`ifdef SWITCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic [MODE_W-1:0]                mode_req = '0;
  logic                             mode_req_valid = 1'b0;
  logic                             mode_req_ready;
  logic [N_MODES-1:0]               ctrl_busy = '0;
  logic [N_MODES*N_BUF*BCTRL_W-1:0] buf_ctrl_in = '0;
  logic [N_MODES*PCTRL_W-1:0]       pea_ctrl_in = '0;
  logic [N_MODES*N_BUF*BSEL_W-1:0]  route_in = '0;
  logic [N_BUF*DATA_W-1:0]          buf_rdata = '0;
  logic [DATA_W-1:0]                pea_out_bus = '0;
  logic [N_BUF*BCTRL_W-1:0]         buf_ctrl_out;
  logic [PCTRL_W-1:0]               pea_ctrl_out;
  logic [N_BUF*DATA_W-1:0]          pea_in_bus;
  logic [N_BUF*DATA_W-1:0]          buf_wdata;
  logic [MODE_W-1:0]                mode_active;
  logic                             switching;
  logic                             bad_mode;
  logic [15:0]                      switch_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int m_mode    = 0;
  bit m_bad     = 1'b0;
  int m_count   = 0;
  bit force_swap = 1'b0;

  always #5 clk = ~clk;

  buffer_pea_switch #(
    .N_MODES (N_MODES), .N_BUF (N_BUF), .DATA_W (DATA_W), .BCTRL_W (BCTRL_W),
    .PCTRL_W (PCTRL_W), .GUARD (GUARD), .MODE_W (MODE_W), .BSEL_W (BSEL_W)
  ) dut (
    .clk (clk), .rst (rst), .mode_req (mode_req), .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready), .ctrl_busy (ctrl_busy), .buf_ctrl_in (buf_ctrl_in),
    .pea_ctrl_in (pea_ctrl_in), .route_in (route_in), .buf_rdata (buf_rdata),
    .pea_out_bus (pea_out_bus), .buf_ctrl_out (buf_ctrl_out), .pea_ctrl_out (pea_ctrl_out),
    .pea_in_bus (pea_in_bus), .buf_wdata (buf_wdata), .mode_active (mode_active),
    .switching (switching), .bad_mode (bad_mode), .switch_count (switch_count)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_BUF*BCTRL_W-1:0] ref_buf(input int m);
    if (m < 1 || m > N_MODES) return '0;
    return buf_ctrl_in[(m-1)*N_BUF*BCTRL_W +: N_BUF*BCTRL_W];
  endfunction

  function automatic logic [PCTRL_W-1:0] ref_pea(input int m);
    if (m < 1 || m > N_MODES) return '0;
    return pea_ctrl_in[(m-1)*PCTRL_W +: PCTRL_W];
  endfunction

  function automatic logic [N_BUF*DATA_W-1:0] ref_bus(input int m);
    logic [N_BUF*DATA_W-1:0] r;
    int src;
    for (int j = 0; j < N_BUF; j++) begin
      if (m == 0) src = j;
      else src = int'(route_in[((m-1)*N_BUF + j)*BSEL_W +: BSEL_W]);
      if (src >= N_BUF) src = 0;
      r[j*DATA_W +: DATA_W] = buf_rdata[src*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // One clock: fresh random data/control inputs, then check every output against the model
  task automatic cycle(input int exp_mode, input bit exp_ready, input bit exp_sw);
    logic [N_BUF*BCTRL_W-1:0] eb;
    logic [PCTRL_W-1:0]       ep;
    buf_ctrl_in = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    pea_ctrl_in = 192'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    route_in    = 6'($urandom());
    if (force_swap) route_in[5:4] = 2'b01;
    buf_rdata   = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
    pea_out_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
    eb = ref_buf(m_mode);
    ep = ref_pea(m_mode);
    @(posedge clk);
    #1;
    m_mode = exp_mode;
    chk("mode_active", 256'(mode_active), 256'(exp_mode));
    chk("ready", 256'(mode_req_ready), 256'(exp_ready));
    chk("switching", 256'(switching), 256'(exp_sw));
    chk("buf_ctrl_out", 256'(buf_ctrl_out), 256'(eb));
    chk("pea_ctrl_out", 256'(pea_ctrl_out), 256'(ep));
    chk("pea_in_bus", 256'(pea_in_bus), 256'(ref_bus(m_mode)));
    chk("buf_wdata", 256'(buf_wdata), 256'({pea_out_bus, pea_out_bus}));
    chk("bad_mode", 256'(bad_mode), 256'(m_bad));
    chk("switch_count", 256'(switch_count), CNT_EN ? 256'(m_count) : 256'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode_req_valid = 1'b0;
    @(posedge clk);
    #1;
    m_mode = 0; m_bad = 1'b0; m_count = 0;
    chk("rst_mode", 256'(mode_active), 256'(0));
    chk("rst_ready", 256'(mode_req_ready), 256'(1));
    chk("rst_switching", 256'(switching), 256'(0));
    chk("rst_buf_ctrl", 256'(buf_ctrl_out), 256'(0));
    chk("rst_pea_ctrl", 256'(pea_ctrl_out), 256'(0));
    chk("rst_bad", 256'(bad_mode), 256'(0));
    chk("rst_count", 256'(switch_count), 256'(0));
    rst = 1'b0;
  endtask

  // Ignored traffic while switching: random valid/mode and random busy on other controllers
  task automatic noise(input int cur);
    mode_req_valid = 1'($urandom());
    mode_req       = 3'($urandom());
    ctrl_busy      = 3'($urandom());
    if (cur != 0) ctrl_busy[cur-1] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mode_req_valid = 1'b0;
      ctrl_busy = 3'($urandom());
      cycle(m_mode, 1'b1, 1'b0);
    end
  endtask

  // Issue one request and follow the expected drain / guard / grant schedule
  task automatic request(input logic [MODE_W-1:0] raw, input int busy_cycles);
    int newm;
    int cur;
    cur  = m_mode;
    newm = (int'(raw) > N_MODES) ? 0 : int'(raw);
    mode_req = raw;
    mode_req_valid = 1'b1;
    ctrl_busy = 3'($urandom());
    if (int'(raw) > N_MODES) m_bad = 1'b1;
    if (newm == cur) begin
      cycle(cur, 1'b1, 1'b0);
      mode_req_valid = 1'b0;
      return;
    end
    if (cur != 0) begin
      cycle(cur, 1'b0, 1'b1);
      for (int i = 0; i <= busy_cycles; i++) begin
        noise(cur);
        ctrl_busy[cur-1] = (i < busy_cycles);
        if (i < busy_cycles) cycle(cur, 1'b0, 1'b1);
        else cycle(0, 1'b0, 1'b1);
      end
    end else begin
      cycle(0, 1'b0, 1'b1);
    end
    for (int g = 1; g < GUARD; g++) begin
      noise(0);
      cycle(0, 1'b0, 1'b1);
    end
    noise(0);
    m_count++;
    cycle(newm, 1'b1, 1'b0);
    mode_req_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(2);
    request(3'd1, 0);
    idle(3);
    request(3'd2, 5);
    idle(2);
    request(3'd3, 0);
    force_swap = 1'b1;
    idle(1);
    chk("swap_bus0", 256'(pea_in_bus[127:0]), 256'(buf_rdata[255:128]));
    chk("swap_bus1", 256'(pea_in_bus[255:128]), 256'(buf_rdata[127:0]));
    force_swap = 1'b0;
    request(3'd5, 1);
    idle(2);
    request(3'd1, 1);
    request(3'd1, 0);
    request(3'd2, 2);
    idle(1);
    // Reset in the middle of the guard window drops the pending mode
    do_reset();
    mode_req = 3'd3;
    mode_req_valid = 1'b1;
    cycle(0, 1'b0, 1'b1);
    mode_req_valid = 1'b0;
    do_reset();
    idle(GUARD + 3);
    for (int n = 0; n < 40; n++) begin
      request(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
